aes_top: RTL and testbench

AES_TOP -- requirements
Module: aes_top

---
 rtl/aes_top.sv | 176 +++++++++++++++++
 tb/tb_aes_top.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_top.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key expansion.
// A 0->1 transition on AES_en loads the block and key. Ten cycles later the ciphertext
// appears on AES_data_out with a one-cycle AES_data_out_valid pulse.
module aes_top (
  input  logic         AES_clk,
  input  logic         AES_rst_n,  // active-high despite the name
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);

  // FIPS-197 S-box; byte x sits at bit offset 8*(255-x), i.e. {~x, 3'b000}.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxTable[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Round constant used to derive the key of round n from the key of round n-1.
  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    case (n)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic          en_q;
  logic [127:0]  st_q;
  logic [127:0]  rk_q;
  logic [3:0]    cnt_q;
  logic [127:0]  next_rk;
  logic [127:0]  sub_shift;
  logic [127:0]  mixed;
  logic [127:0]  round_out;
  logic          start;
  logic          load;
  logic          step;
  logic          last;

  assign start = AES_en & ~en_q;

  // Key expansion: derive the round key for round cnt_q from the previous one.
  always_comb begin
    logic [31:0] w0, w1, w2, w3, rot, sub, t;
    w0 = rk_q[127:96];
    w1 = rk_q[95:64];
    w2 = rk_q[63:32];
    w3 = rk_q[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t = sub ^ {rcon(cnt_q), 24'h000000};
    next_rk[127:96] = w0 ^ t;
    next_rk[95:64]  = w0 ^ t ^ w1;
    next_rk[63:32]  = w0 ^ t ^ w1 ^ w2;
    next_rk[31:0]   = w0 ^ t ^ w1 ^ w2 ^ w3;
  end

  // Round datapath: SubBytes + ShiftRows, MixColumns (skipped in round 10), AddRoundKey.
  always_comb begin
    sub_shift = '0;
    mixed = '0;
    for (int i = 0; i < 16; i++) begin
      // Output byte (row r, col c) takes input byte (r, (c + r) mod 4).
      int src;
      src = 4 * (((i / 4) + (i % 4)) % 4) + (i % 4);
      sub_shift[127 - 8 * i -: 8] = sbox(st_q[127 - 8 * src -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32 * c -: 32] = mix_col(sub_shift[127 - 32 * c -: 32]);
    end
    round_out = ((cnt_q == 4'd10) ? sub_shift : mixed) ^ next_rk;
  end

  // FSM state register.
  always_ff @(posedge AES_clk or posedge AES_rst_n) begin
    if (AES_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == 4'd10) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: datapath control strobes.
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    last = 1'b0;
    case (state_q)
      StIdle: load = start;
      StRun: begin
        step = 1'b1;
        last = (cnt_q == 4'd10);
      end
      default: ;
    endcase
  end

  // Datapath registers, edge-detect sample and result register.
  always_ff @(posedge AES_clk or posedge AES_rst_n) begin
    if (AES_rst_n) begin
      en_q               <= 1'b0;
      st_q               <= '0;
      rk_q               <= '0;
      cnt_q              <= 4'd0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
    end else begin
      en_q               <= AES_en;
      AES_data_out_valid <= last;
      if (load) begin
        st_q  <= AES_data_in ^ AES_key_in;
        rk_q  <= AES_key_in;
        cnt_q <= 4'd1;
      end else if (step) begin
        st_q  <= round_out;
        rk_q  <= next_rk;
        cnt_q <= last ? 4'd0 : cnt_q + 4'd1;
      end
      if (last) begin
        AES_data_out <= round_out;
      end
    end
  end

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: directed FIPS-197 vectors, protocol corner cases and
// random blocks checked against a byte-level AES-128 model built from GF(2^8) arithmetic.
module tb_aes_top;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [127:0] din = '0;
  logic [127:0] key = '0;
  logic [127:0] dout;
  logic         valid;

  int total = 0;
  int bad = 0;
  logic [7:0] sb [256];

  aes_top dut (
    .AES_clk           (clk),
    .AES_rst_n         (rst),
    .AES_en            (en),
    .AES_data_in       (din),
    .AES_key_in        (key),
    .AES_data_out      (dout),
    .AES_data_out_valid(valid)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, xb, yb;
      inv = 8'h00;
      xb = x[7:0];
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          yb = y[7:0];
          if (gmul(xb, yb) == 8'h01) inv = yb;
        end
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  a [4];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ k[127 - 8 * i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[4 * c + row] = t[4 * ((c + row) % 4) + row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4 * c + j];
          for (int j = 0; j < 4; j++)
            s[4 * c + j] = gmul(a[j], 8'h02) ^ gmul(a[(j + 1) % 4], 8'h03)
                         ^ a[(j + 2) % 4] ^ a[(j + 3) % 4];
        end
      end
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          s[4 * c + j] = s[4 * c + j] ^ w[4 * r + c][31 - 8 * j -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drop AES_en for one cycle, then raise it with new operands; the next posedge is E0.
  task automatic start(input logic [127:0] d, input logic [127:0] k);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    din = d;
    key = k;
    en = 1'b1;
  endtask

  // Wait from E0 for the valid pulse; optionally scramble inputs and AES_en while running.
  task automatic wait_done(input string tag, input bit scramble, input bit toggle_en);
    int lat;
    lat = 0;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = n;
        break;
      end
      if (scramble) begin
        din = rand128();
        key = rand128();
      end
      if (toggle_en) en = $urandom_range(0, 1) != 0;
    end
    check({tag, "_latency"}, 128'(lat), 128'd10);
  endtask

  task automatic run_vec(input string tag, input logic [127:0] d, input logic [127:0] k,
                         input logic [127:0] exp, input bit scramble, input bit toggle_en);
    start(d, k);
    wait_done(tag, scramble, toggle_en);
    check({tag, "_out"}, dout, exp);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, 128'(valid), 128'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] d, k, exp, d2, k2, prev;
    int pulses;

    build_sbox();

    // Reset state.
    #1;
    check("reset_out", dout, 128'd0);
    check("reset_valid", 128'(valid), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Model sanity against the published FIPS-197 vectors.
    check("model_c1", aes_ref(128'h00112233445566778899aabbccddeeff,
                              128'h000102030405060708090a0b0c0d0e0f),
          128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Known-answer vectors.
    run_vec("fips_c1", 128'h00112233445566778899aabbccddeeff,
            128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 0);
    run_vec("fips_b", 128'h3243f6a8885a308d313198a2e0370734,
            128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32, 0, 0);

    // All-zero vector with AES_en held high for 51 cycles: one pulse only.
    start('0, '0);
    pulses = 0;
    for (int i = 0; i < 51; i++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    check("hold_en_pulses", 128'(pulses), 128'd1);
    check("zero_out", dout, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

    // Output holds with inputs changing and AES_en low.
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din = rand128();
      key = rand128();
    end
    check("hold_out", dout, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

    // Inputs changed every cycle mid-run.
    d = 128'ha6f2daeb0123456789abcdef55aa55aa;
    k = rand128();
    run_vec("scramble", d, k, aes_ref(d, k), 1, 0);

    // Reset at round 5 aborts with no pulse.
    d = rand128();
    k = rand128();
    start(d, k);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out", dout, 128'd0);
    check("abort_valid", 128'(valid), 128'd0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    check("abort_no_pulse", 128'(pulses), 128'd0);
    d = rand128();
    k = rand128();
    run_vec("after_abort", d, k, aes_ref(d, k), 0, 0);

    // Back-to-back: valid, AES_en low one cycle, then second start.
    d = rand128();
    k = rand128();
    d2 = rand128();
    k2 = rand128();
    start(d, k);
    wait_done("b2b_first", 0, 0);
    check("b2b_first_out", dout, aes_ref(d, k));
    prev = dout;
    start(d2, k2);
    wait_done("b2b_second", 0, 0);
    check("b2b_second_out", dout, aes_ref(d2, k2));

    // AES_en already high when reset releases counts as a start.
    @(negedge clk);
    rst = 1'b1;
    d = rand128();
    k = rand128();
    din = d;
    key = k;
    en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_done("rel_start", 0, 0);
    check("rel_start_out", dout, aes_ref(d, k));

    // Random blocks with AES_en toggling and operands scrambled mid-run.
    for (int i = 0; i < 8; i++) begin
      d = rand128();
      k = rand128();
      exp = aes_ref(d, k);
      run_vec($sformatf("rand%0d", i), d, k, exp, 1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
